stream_split_using_double_buffers: RTL and testbench
====================================================

Name: stream_split_using_double_buffers

Overview:
- Split block, the reverse of the two-input a-plus-b join.
- Accepts one valid/ready upstream stream of packed operand pairs and fans it out to two independent valid/ready downstream streams, a and b.
- Each downstream leg has its own 2-entry double buffer, so a slow consumer on one leg does not stall the other until that leg's buffer fills.
- Acts as the stimulus-side counterpart that feeds the a/b inputs of the join pipeline from a single source.

Parameters:
- width, 4, bit width of each output operand; upstream word is 2*width bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- up_valid  input  1  upstream word valid.
- up_ready  output  1  block can accept upstream word.
- up_data  input  2*width  packed pair: a operand in [2*width-1:width], b operand in [width-1:0].
- a_valid  output  1  a leg holds data.
- a_ready  input  1  a consumer accepts.
- a_data  output  width  a operand.
- b_valid  output  1  b leg holds data.
- b_ready  input  1  b consumer accepts.
- b_data  output  width  b operand.

Behaviour:
- Transfers: an upstream transfer occurs on a clock edge with up_valid & up_ready. A leg transfer occurs on a clock edge with x_valid & x_ready (x = a or b).
- Leg buffer: each leg is a 2-slot buffer with wr_ptr (1 bit), rd_ptr (1 bit), and full/empty state.
- x_valid = ~empty; x_data = slot[rd_ptr]. Data is held stable while x_valid & ~x_ready.
- up_ready = ~rst & ~a_full & ~b_full. It depends only on registered state and rst, never combinationally on a_ready, b_ready or up_valid.
- Upstream transfer: writes the upper half into a slot[wr_ptr] and the lower half into b slot[wr_ptr]. Both legs always receive the word on the same edge.
- Latency: the first word appears on x_valid/x_data one cycle after its upstream transfer. There is no combinational bypass from up_data to x_data.
- Occupancy, per leg:
  - push only: empty->1 entry, 1 entry->full.
  - pop only: full->1 entry, 1 entry->empty.
  - push & pop at 1 entry: stays at 1 entry, both pointers advance.
  - push at full: impossible, since up_ready=0.
  - pop at empty: impossible, since x_valid=0.
- Throughput: with both consumers ready every cycle, one word per cycle is sustained after the first.
- Legs drain independently. Once one leg is full, up_ready=0 even if the other leg is empty.
- Per-leg ordering is strictly FIFO. The k-th a transfer and the k-th b transfer carry halves of the same k-th upstream word.
- Pointers wrap 1->0 naturally (1-bit).
- Reset, asserted at any time (including mid-transfer): immediately clears both buffers to empty and pointers to 0.
  - During reset: a_valid=0, b_valid=0, up_ready=0.
  - Buffered words are discarded.
  - Slot data registers need not be reset; x_data is don't-care while x_valid=0.
  - After rst deasserts: up_ready=1 in the first cycle.
- Arithmetic: none; the split is a pure slicing of up_data, with no width extension.

Test Plan:
- Back-to-back: reset, then up_valid=1 with words 8'h12, 8'h34, 8'h56, a_ready=b_ready=1 -> one word per cycle after a 1-cycle latency; a sequence 1,3,5; b sequence 2,4,6; up_ready stays 1.
- a stalled: a_ready=0, b_ready=1, send 8'hA1, 8'hB2, 8'hC3 -> first two words accepted, then up_ready=0. b delivers 1,2. a holds a_data=A stable with a_valid=1. Raising a_ready -> a gives A,B, then C3 is accepted.
- b stalled: mirror of the previous case with b_ready=0 -> up_ready drops after 2 accepts; a delivers 2 words then a_valid=0.
- Full backpressure: a_ready=b_ready=0, up_valid=1 for 10 cycles -> exactly 2 upstream transfers; a_valid=b_valid=1 with the first word held. Release both -> words appear in order, each exactly once.
- Reset mid-operation: both legs full, assert rst asynchronously between edges -> a_valid, b_valid, up_ready go 0 without waiting for a clock edge. After release, the next word 8'h7E yields a=7, b=E and no stale data.
- Random: random up_valid/a_ready/b_ready over 100 words, scoreboard checked against a queue of pushed words -> no loss, duplication or reordering; a_count == b_count == 100 after drain.

Source files
------------

// File: rtl/stream_split_using_double_buffers_if.sv
// Purpose : handshake bundle for the stream splitter (one upstream pair stream, two operand legs).
// Ports   : up_valid/up_ready/up_data (2*width packed pair), a_valid/a_ready/a_data, b_valid/b_ready/b_data.
// Modports: slave = splitter side, master = the environment that sources up and sinks a/b.
interface stream_split_using_double_buffers_if #(
  parameter int width = 4
);
  logic               up_valid;
  logic               up_ready;
  logic [2*width-1:0] up_data;
  logic               a_valid;
  logic               a_ready;
  logic [width-1:0]   a_data;
  logic               b_valid;
  logic               b_ready;
  logic [width-1:0]   b_data;

  modport slave (
    input  up_valid, up_data, a_ready, b_ready,
    output up_ready, a_valid, a_data, b_valid, b_data
  );

  modport master (
    output up_valid, up_data, a_ready, b_ready,
    input  up_ready, a_valid, a_data, b_valid, b_data
  );
endinterface

// File: rtl/stream_split_using_double_buffers.sv
// Purpose : splits each upstream word into an a half (upper) and a b half (lower), one 2-slot buffer per leg.
// Latency : one cycle from upstream transfer to x_valid; no combinational path up_data -> x_data.
// Backpressure: up_ready drops as soon as either leg is full; legs drain independently.
// Ports   : clk, rst (async active-high), s = slave modport carrying up/a/b valid-ready streams.
module stream_split_using_double_buffers #(
  parameter int width = 4
) (
  input logic                               clk,
  input logic                               rst,
  stream_split_using_double_buffers_if.slave s
);

  logic             up_ready_int;
  logic             push;
  logic [1:0]       leg_full;
  logic [1:0]       leg_valid;
  logic [1:0]       leg_ready;
  logic [width-1:0] leg_in  [2];
  logic [width-1:0] leg_out [2];

  // Index 0 is the a leg (upper half), index 1 the b leg (lower half).
  assign leg_in[0]    = s.up_data[2*width-1:width];
  assign leg_in[1]    = s.up_data[width-1:0];
  assign leg_ready[0] = s.a_ready;
  assign leg_ready[1] = s.b_ready;

  // Registered state plus rst only: never depends on the consumers' ready inputs.
  assign up_ready_int = ~rst & ~leg_full[0] & ~leg_full[1];
  assign push         = s.up_valid & up_ready_int;

  assign s.up_ready = up_ready_int;
  assign s.a_valid  = leg_valid[0];
  assign s.a_data   = leg_out[0];
  assign s.b_valid  = leg_valid[1];
  assign s.b_data   = leg_out[1];

  for (genvar g = 0; g < 2; g++) begin : g_leg
    logic [width-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;   // 0 = empty, 1 = one entry, 2 = full
    logic             pop;

    assign pop          = leg_valid[g] & leg_ready[g];
    assign leg_valid[g] = (count != 2'd0);
    assign leg_full[g]  = (count == 2'd2);
    assign leg_out[g]   = slot[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        // push at full and pop at empty cannot occur, so no saturation is needed
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end

    // Slot contents are only meaningful while counted, so they carry no reset.
    always_ff @(posedge clk) begin
      if (push) slot[wr_ptr] <= leg_in[g];
    end
  end

endmodule

// File: tb/tb_stream_split_using_double_buffers.sv
module tb_stream_split_using_double_buffers;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stream_split_using_double_buffers_if #(.width(4)) bus ();

  stream_split_using_double_buffers #(.width(4)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set here are seen by the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] a_q [$];
  logic [3:0] b_q [$];
  logic [7:0] word;
  logic [3:0] exp_n;
  int         sent;
  int         a_count;
  int         b_count;
  int         xfers;
  int         cyc;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.up_valid = 1'b0;
    bus.up_data  = 8'h00;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    #1 rst = 1'b1;
    step();
    chk("rst_up_ready", 32'(bus.up_ready), 32'd0);
    chk("rst_a_valid",  32'(bus.a_valid),  32'd0);
    chk("rst_b_valid",  32'(bus.b_valid),  32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_up_ready", 32'(bus.up_ready), 32'd1);

    // Back-to-back with both consumers ready
    bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    bus.up_valid = 1'b1; bus.up_data = 8'h12;
    step();
    chk("bb_a0", 32'(bus.a_data), 32'h1);
    chk("bb_b0", 32'(bus.b_data), 32'h2);
    chk("bb_av0", 32'(bus.a_valid), 32'd1);
    chk("bb_rdy0", 32'(bus.up_ready), 32'd1);
    bus.up_data = 8'h34;
    step();
    chk("bb_a1", 32'(bus.a_data), 32'h3);
    chk("bb_b1", 32'(bus.b_data), 32'h4);
    chk("bb_rdy1", 32'(bus.up_ready), 32'd1);
    bus.up_data = 8'h56;
    step();
    chk("bb_a2", 32'(bus.a_data), 32'h5);
    chk("bb_b2", 32'(bus.b_data), 32'h6);
    chk("bb_rdy2", 32'(bus.up_ready), 32'd1);
    bus.up_valid = 1'b0;
    step();
    chk("bb_av_end", 32'(bus.a_valid), 32'd0);
    chk("bb_bv_end", 32'(bus.b_valid), 32'd0);

    // a leg stalled
    bus.a_ready = 1'b0; bus.b_ready = 1'b1;
    bus.up_valid = 1'b1; bus.up_data = 8'hA1;
    step();
    chk("as_b0", 32'(bus.b_data), 32'h1);
    chk("as_rdy0", 32'(bus.up_ready), 32'd1);
    bus.up_data = 8'hB2;
    step();
    chk("as_b1", 32'(bus.b_data), 32'h2);
    chk("as_rdy1", 32'(bus.up_ready), 32'd0);
    chk("as_a_hold1", 32'(bus.a_data), 32'hA);
    bus.up_data = 8'hC3;
    step();
    chk("as_bv2", 32'(bus.b_valid), 32'd0);
    chk("as_av2", 32'(bus.a_valid), 32'd1);
    chk("as_a_hold2", 32'(bus.a_data), 32'hA);
    chk("as_rdy2", 32'(bus.up_ready), 32'd0);
    step();
    chk("as_a_hold3", 32'(bus.a_data), 32'hA);
    bus.a_ready = 1'b1;
    step();
    chk("as_a_next", 32'(bus.a_data), 32'hB);
    chk("as_rdy_back", 32'(bus.up_ready), 32'd1);
    step();
    chk("as_a_c", 32'(bus.a_data), 32'hC);
    chk("as_b_c", 32'(bus.b_data), 32'h3);
    bus.up_valid = 1'b0;
    step();
    chk("as_av_end", 32'(bus.a_valid), 32'd0);

    // b leg stalled
    bus.a_ready = 1'b1; bus.b_ready = 1'b0;
    bus.up_valid = 1'b1; bus.up_data = 8'hD4;
    step();
    chk("bs_a0", 32'(bus.a_data), 32'hD);
    bus.up_data = 8'hE5;
    step();
    chk("bs_a1", 32'(bus.a_data), 32'hE);
    chk("bs_rdy1", 32'(bus.up_ready), 32'd0);
    chk("bs_b_hold1", 32'(bus.b_data), 32'h4);
    bus.up_data = 8'hF6;
    step();
    chk("bs_av2", 32'(bus.a_valid), 32'd0);
    chk("bs_b_hold2", 32'(bus.b_data), 32'h4);
    bus.b_ready = 1'b1;
    step();
    chk("bs_b_next", 32'(bus.b_data), 32'h5);
    chk("bs_rdy_back", 32'(bus.up_ready), 32'd1);
    step();
    chk("bs_b_f", 32'(bus.b_data), 32'h6);
    chk("bs_a_f", 32'(bus.a_data), 32'hF);
    bus.up_valid = 1'b0;
    step();
    chk("bs_bv_end", 32'(bus.b_valid), 32'd0);

    // Full backpressure: 10 cycles offered, only 2 words fit
    bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    bus.up_valid = 1'b1;
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      case (xfers)
        0:       bus.up_data = 8'h21;
        1:       bus.up_data = 8'h43;
        default: bus.up_data = 8'h65;
      endcase
      if (bus.up_ready) xfers++;
      step();
    end
    chk("fb_xfers", 32'(xfers), 32'd2);
    chk("fb_av", 32'(bus.a_valid), 32'd1);
    chk("fb_bv", 32'(bus.b_valid), 32'd1);
    chk("fb_a_hold", 32'(bus.a_data), 32'h2);
    chk("fb_b_hold", 32'(bus.b_data), 32'h1);
    bus.up_valid = 1'b0;
    bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    step();
    chk("fb_a1", 32'(bus.a_data), 32'h4);
    chk("fb_b1", 32'(bus.b_data), 32'h3);
    step();
    chk("fb_av_end", 32'(bus.a_valid), 32'd0);
    chk("fb_bv_end", 32'(bus.b_valid), 32'd0);

    // Asynchronous reset with both legs full
    bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    bus.up_valid = 1'b1; bus.up_data = 8'h9A;
    step();
    bus.up_data = 8'hBC;
    step();
    bus.up_valid = 1'b0;
    chk("ar_full_rdy", 32'(bus.up_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_av", 32'(bus.a_valid), 32'd0);
    chk("ar_bv", 32'(bus.b_valid), 32'd0);
    chk("ar_rdy", 32'(bus.up_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("ar_rdy_after", 32'(bus.up_ready), 32'd1);
    chk("ar_av_after", 32'(bus.a_valid), 32'd0);
    bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    bus.up_valid = 1'b1; bus.up_data = 8'h7E;
    step();
    chk("ar_a_7", 32'(bus.a_data), 32'h7);
    chk("ar_b_e", 32'(bus.b_data), 32'hE);
    bus.up_valid = 1'b0;
    step();
    chk("ar_no_stale_a", 32'(bus.a_valid), 32'd0);
    chk("ar_no_stale_b", 32'(bus.b_valid), 32'd0);

    // Random traffic against a scoreboard
    sent = 0; a_count = 0; b_count = 0; cyc = 0;
    word = 8'($urandom_range(0, 255));
    while ((sent < 100 || a_q.size() != 0 || b_q.size() != 0) && cyc < 5000) begin
      bus.up_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      bus.up_data  = word;
      bus.a_ready  = ($urandom_range(0, 2) != 0);
      bus.b_ready  = ($urandom_range(0, 2) != 0);
      if (bus.a_valid && bus.a_ready) begin
        exp_n = (a_q.size() != 0) ? a_q.pop_front() : 4'hx;
        chk("rnd_a", 32'(bus.a_data), 32'(exp_n));
        a_count++;
      end
      if (bus.b_valid && bus.b_ready) begin
        exp_n = (b_q.size() != 0) ? b_q.pop_front() : 4'hx;
        chk("rnd_b", 32'(bus.b_data), 32'(exp_n));
        b_count++;
      end
      if (bus.up_valid && bus.up_ready) begin
        a_q.push_back(word[7:4]);
        b_q.push_back(word[3:0]);
        sent++;
        word = 8'($urandom_range(0, 255));
      end
      step();
      cyc++;
    end
    bus.up_valid = 1'b0;
    chk("rnd_a_count", 32'(a_count), 32'd100);
    chk("rnd_b_count", 32'(b_count), 32'd100);
    chk("rnd_av_end", 32'(bus.a_valid), 32'd0);
    chk("rnd_bv_end", 32'(bus.b_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
